// File: rtl/nco_phase_gen_if.sv
// Frequency-control-word load channel between the CPU MMIO side and the NCO.
// Handshake: a word moves on a clk edge where fcw_valid && fcw_ready; fcw_in is held stable while valid waits.
interface nco_phase_gen_if #(
  parameter int ACC_WIDTH = 24
) ();
  logic [ACC_WIDTH-1:0] fcw_in;
  logic                 fcw_valid;
  logic                 fcw_ready;

  modport master (
    output fcw_in,
    output fcw_valid,
    input  fcw_ready
  );

  modport slave (
    input  fcw_in,
    input  fcw_valid,
    output fcw_ready
  );
endinterface

// File: rtl/nco_phase_gen.sv
// Phase-accumulator NCO: advances by the active FCW once per divided sample tick and
// registers the top PHASE_WIDTH bits; new FCWs go through a shadow register applied on a tick.
module nco_phase_gen #(
  parameter int ACC_WIDTH   = 24,
  parameter int PHASE_WIDTH = 15,
  parameter int CLK_DIV     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   sync_reset,
  nco_phase_gen_if.slave         fcw_if,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic                   phase_valid,
  output logic                   wrap,
  output logic                   state_dbg
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [ACC_WIDTH-1:0]   active_fcw_q, active_fcw_d;
  logic [ACC_WIDTH-1:0]   shadow_q, shadow_d;
  logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic                   phase_valid_q, phase_valid_d;
  logic                   wrap_q, wrap_d;
  logic                   tick;
  logic [ACC_WIDTH:0]     sum;

  // A hard sync swallows the tick of its cycle, including any FCW apply.
  assign tick = enable && !sync_reset && (div_cnt_q == DIV_LAST);
  assign sum  = {1'b0, acc_q} + {1'b0, active_fcw_q};

  assign fcw_if.fcw_ready = (state_q == ST_EMPTY);
  assign phase            = phase_q;
  assign phase_valid      = phase_valid_q;
  assign wrap             = wrap_q;
  assign state_dbg        = state_q;

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    active_fcw_d = active_fcw_q;
    case (state_q)
      ST_EMPTY: begin
        if (fcw_if.fcw_valid) begin
          shadow_d = fcw_if.fcw_in;
          state_d  = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (tick) begin
          active_fcw_d = shadow_q;
          state_d      = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // The add on an apply tick still uses the old FCW (active_fcw_q).
  always_comb begin
    acc_d         = acc_q;
    div_cnt_d     = div_cnt_q;
    phase_d       = phase_q;
    phase_valid_d = 1'b0;
    wrap_d        = 1'b0;
    if (sync_reset) begin
      acc_d     = '0;
      div_cnt_d = '0;
      phase_d   = '0;
    end else if (enable) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
      if (tick) begin
        acc_d         = sum[ACC_WIDTH-1:0];
        phase_d       = sum[ACC_WIDTH-1 -: PHASE_WIDTH];
        phase_valid_d = 1'b1;
        wrap_d        = sum[ACC_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_EMPTY;
      acc_q         <= '0;
      active_fcw_q  <= '0;
      shadow_q      <= '0;
      div_cnt_q     <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      active_fcw_q  <= active_fcw_d;
      shadow_q      <= shadow_d;
      div_cnt_q     <= div_cnt_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      wrap_q        <= wrap_d;
    end
  end

endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed bench for nco_phase_gen: CLK_DIV=4 instance for streaming/retune/sync/enable cases,
// CLK_DIV=1 instance for the slow-FCW and reset-with-pending cases.
module tb_nco_phase_gen;

  logic        clk;
  logic        rst;
  logic        enable, sync_reset;
  logic        enable1, sync_reset1;
  logic [14:0] phase, phase1;
  logic        phase_valid, wrap, state_dbg;
  logic        phase_valid1, wrap1, state_dbg1;

  nco_phase_gen_if #(.ACC_WIDTH(24)) if0 ();
  nco_phase_gen_if #(.ACC_WIDTH(24)) if1 ();

  nco_phase_gen #(.ACC_WIDTH(24), .PHASE_WIDTH(15), .CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sync_reset(sync_reset),
    .fcw_if(if0), .phase(phase), .phase_valid(phase_valid), .wrap(wrap),
    .state_dbg(state_dbg)
  );

  nco_phase_gen #(.ACC_WIDTH(24), .PHASE_WIDTH(15), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable1), .sync_reset(sync_reset1),
    .fcw_if(if1), .phase(phase1), .phase_valid(phase_valid1), .wrap(wrap1),
    .state_dbg(state_dbg1)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [14:0] exp_q[$];
  logic [14:0] ph_q[$];
  logic        wr_q[$];
  int          t_q[$];
  int          cyc_cnt = 0;

  always @(negedge clk) begin
    cyc_cnt++;
    if (!rst && phase_valid) begin
      ph_q.push_back(phase);
      wr_q.push_back(wrap);
      t_q.push_back(cyc_cnt);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    rst           = 1'b1;
    enable        = 1'b0;
    sync_reset    = 1'b0;
    enable1       = 1'b0;
    sync_reset1   = 1'b0;
    if0.fcw_valid = 1'b0;
    if0.fcw_in    = '0;
    if1.fcw_valid = 1'b0;
    if1.fcw_in    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ph_q.delete();
    wr_q.delete();
    t_q.delete();
    exp_q.delete();
  endtask

  // Returns on the negedge after the accepting clock edge; waited = cycles stalled on ready.
  task automatic send_fcw(input logic [23:0] v, input int max_wait, output int waited);
    waited         = 0;
    if0.fcw_in    = v;
    if0.fcw_valid = 1'b1;
    while (!if0.fcw_ready && waited < max_wait) begin
      @(negedge clk);
      waited++;
    end
    check_eq("fcw_ready_before_accept", {31'd0, if0.fcw_ready}, 32'd1);
    @(negedge clk);
    if0.fcw_valid = 1'b0;
    if0.fcw_in    = '0;
  endtask

  task automatic wait_samples(input int n, input int max_cyc);
    int c;
    c = 0;
    while (ph_q.size() < n && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    check_eq("sample_count", ph_q.size(), n);
  endtask

  initial begin
    int   w;
    int   n;
    logic pv_seen;
    int   zeros, total, cycles;
    logic [14:0] first_nz;

    // Reset state
    do_reset();
    check_eq("rst_phase", {17'd0, phase}, 32'd0);
    check_eq("rst_phase_valid", {31'd0, phase_valid}, 32'd0);
    check_eq("rst_wrap", {31'd0, wrap}, 32'd0);
    check_eq("rst_fcw_ready", {31'd0, if0.fcw_ready}, 32'd1);
    check_eq("rst_state", {31'd0, state_dbg}, 32'd0);

    // Stream at FCW 0x100000: apply sample 0, then 0x0800..0x7800, then 0 with wrap
    enable = 1'b1;
    send_fcw(24'h100000, 10, w);
    check_eq("t1_accept_wait", w, 0);
    exp_q.push_back(15'h0000);
    for (int k = 1; k <= 15; k++) exp_q.push_back(15'(k * 'h800));
    exp_q.push_back(15'h0000);
    wait_samples(17, 100);
    n = ph_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("t1_phase[%0d]", i), {17'd0, ph_q[i]}, {17'd0, exp_q.pop_front()});
      check_eq($sformatf("t1_wrap[%0d]", i), {31'd0, wr_q[i]}, (i == 16) ? 32'd1 : 32'd0);
      if (i > 0) check_eq($sformatf("t1_gap[%0d]", i), t_q[i] - t_q[i-1], 4);
    end

    // Back-to-back loads: second FCW stalls until the apply tick, then retune steps 0x800 then 0x1000
    do_reset();
    enable = 1'b1;
    send_fcw(24'h100000, 10, w);
    check_eq("t2_ready_pending", {31'd0, if0.fcw_ready}, 32'd0);
    send_fcw(24'h200000, 20, w);
    check_eq("t2_stall_cycles", w, 3);
    check_eq("t2_ready_after_second", {31'd0, if0.fcw_ready}, 32'd0);
    exp_q.push_back(15'h0000);
    exp_q.push_back(15'h0800);
    exp_q.push_back(15'h1800);
    exp_q.push_back(15'h2800);
    wait_samples(4, 60);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t3_phase[%0d]", i), {17'd0, ph_q[i]}, {17'd0, exp_q.pop_front()});
      if (i > 0) check_eq($sformatf("t3_gap[%0d]", i), t_q[i] - t_q[i-1], 4);
    end

    // sync_reset on the tick cycle following phase 0x3000
    do_reset();
    enable = 1'b1;
    send_fcw(24'h100000, 10, w);
    repeat (27) @(negedge clk);
    check_eq("t4_pre_valid", {31'd0, phase_valid}, 32'd1);
    check_eq("t4_pre_phase", {17'd0, phase}, 32'h3000);
    repeat (3) @(negedge clk);
    sync_reset = 1'b1;
    @(negedge clk);
    sync_reset = 1'b0;
    check_eq("t4_sync_phase", {17'd0, phase}, 32'h0000);
    check_eq("t4_sync_valid", {31'd0, phase_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("t4_quiet[%0d]", i), {31'd0, phase_valid}, 32'd0);
    end
    @(negedge clk);
    check_eq("t4_post_valid", {31'd0, phase_valid}, 32'd1);
    check_eq("t4_post_phase", {17'd0, phase}, 32'h0800);

    // enable=0 for 10 cycles with div_cnt=2; FCW handshake completes while frozen
    repeat (2) @(negedge clk);
    enable = 1'b0;
    send_fcw(24'h200000, 10, w);
    check_eq("t5_ready_pending", {31'd0, if0.fcw_ready}, 32'd0);
    pv_seen = 1'b0;
    repeat (9) begin
      @(negedge clk);
      if (phase_valid) pv_seen = 1'b1;
    end
    check_eq("t5_no_valid", {31'd0, pv_seen}, 32'd0);
    check_eq("t5_phase_hold", {17'd0, phase}, 32'h0800);
    check_eq("t5_ready_hold", {31'd0, if0.fcw_ready}, 32'd0);
    enable = 1'b1;
    @(negedge clk);
    check_eq("t5_resume_quiet", {31'd0, phase_valid}, 32'd0);
    @(negedge clk);
    check_eq("t5_resume_valid", {31'd0, phase_valid}, 32'd1);
    check_eq("t5_resume_phase", {17'd0, phase}, 32'h1000);
    check_eq("t5_ready_applied", {31'd0, if0.fcw_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check_eq("t5_next_valid", {31'd0, phase_valid}, 32'd1);
    check_eq("t5_next_phase", {17'd0, phase}, 32'h2000);

    // CLK_DIV=1, FCW=1: apply sample plus 511 zero samples, then phase 1
    do_reset();
    if1.fcw_in    = 24'h000001;
    if1.fcw_valid = 1'b1;
    @(negedge clk);
    if1.fcw_valid = 1'b0;
    if1.fcw_in    = '0;
    check_eq("t6_ready_pending", {31'd0, if1.fcw_ready}, 32'd0);
    enable1  = 1'b1;
    zeros    = 0;
    total    = 0;
    cycles   = 0;
    first_nz = '0;
    while (cycles < 600 && first_nz == 15'd0) begin
      @(negedge clk);
      cycles++;
      if (phase_valid1) begin
        total++;
        if (phase1 == 15'd0) zeros++;
        else first_nz = phase1;
      end
    end
    check_eq("t6_zero_samples", zeros, 512);
    check_eq("t6_first_nonzero", {17'd0, first_nz}, 32'd1);
    check_eq("t6_valid_every_cycle", total, cycles);

    // Reset while an FCW is pending: everything returns to idle, old FCW discarded
    enable1       = 1'b0;
    if1.fcw_in    = 24'h000005;
    if1.fcw_valid = 1'b1;
    @(negedge clk);
    if1.fcw_valid = 1'b0;
    if1.fcw_in    = '0;
    check_eq("t6_pending_before_rst", {31'd0, if1.fcw_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_ready", {31'd0, if1.fcw_ready}, 32'd1);
    check_eq("t6_rst_phase", {17'd0, phase1}, 32'd0);
    check_eq("t6_rst_valid", {31'd0, phase_valid1}, 32'd0);
    check_eq("t6_rst_state", {31'd0, state_dbg1}, 32'd0);
    rst     = 1'b0;
    enable1 = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t6_zero_fcw_valid", {31'd0, phase_valid1}, 32'd1);
    check_eq("t6_zero_fcw_phase", {17'd0, phase1}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
